// File: rtl/fpga_top_mul_share_pkg.sv
// Shared types and default widths for the multiplier-sharing arbiter.
// Pipeline entry carries the owning requester alongside the truncated product.
package fpga_top_mul_share_pkg;

   localparam int NUM_REQ_DEF    = 4;
   localparam int A_WIDTH_DEF    = 10;
   localparam int B_WIDTH_DEF    = 10;
   localparam int P_WIDTH_DEF    = 16;
   localparam int MUL_STAGES_DEF = 1;

   typedef logic [$clog2(NUM_REQ_DEF)-1:0] owner_t;

   typedef struct packed {
      logic                   valid;
      owner_t                 owner;
      logic [P_WIDTH_DEF-1:0] p;
   } stage_t;

endpackage

// File: rtl/fpga_top_mul_share_if.sv
// Request/response bundle between the HLS compute loops and the shared multiplier.
interface fpga_top_mul_share_if
   import fpga_top_mul_share_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int A_WIDTH = A_WIDTH_DEF,
   parameter int B_WIDTH = B_WIDTH_DEF,
   parameter int P_WIDTH = P_WIDTH_DEF
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*A_WIDTH-1:0] req_a;
   logic [NUM_REQ*B_WIDTH-1:0] req_b;
   logic [NUM_REQ-1:0]         rsp_valid;
   logic [P_WIDTH-1:0]         rsp_p;
   logic [NUM_REQ-1:0]         rsp_ready;
   logic                       busy;
   logic [31:0]                op_count;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_p, busy, op_count
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_p, busy, op_count
   );

endinterface

// File: rtl/fpga_top_mul_mul_10s_10ns_16_1_1.sv
// Signed-10 x unsigned-10 multiplier core, product wrapped to 16 bits.
module fpga_top_mul_mul_10s_10ns_16_1_1 (
   input  logic [9:0]  din0,
   input  logic [9:0]  din1,
   output logic [15:0] dout
);

   logic signed [15:0] a_ext;
   logic signed [15:0] b_ext;

   // Only the low 16 product bits are kept, so 16-bit extended operands suffice.
   assign a_ext = {{6{din0[9]}}, din0};
   assign b_ext = {6'b0, din1};
   assign dout  = a_ext * b_ext;

endmodule

// File: rtl/fpga_top_mul_share_rr.sv
// Round-robin grant: first asserted request at or above ptr, wrapping modulo NUM_REQ.
module fpga_top_mul_share_rr #(
   parameter int NUM_REQ = 4,
   localparam int IW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx
);

   logic found;
   int   j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         j = (int'(ptr) + off) % NUM_REQ;
         if (en && !found && req[j]) begin
            grant[j] = 1'b1;
            idx      = IW'(j);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fpga_top_mul_share_arbiter.sv
// Shares one multiplier core among NUM_REQ requesters with round-robin grant
// and a stallable MUL_STAGES-deep result pipeline.
module fpga_top_mul_share_arbiter
   import fpga_top_mul_share_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int A_WIDTH    = A_WIDTH_DEF,
   parameter int B_WIDTH    = B_WIDTH_DEF,
   parameter int P_WIDTH    = P_WIDTH_DEF,
   parameter int MUL_STAGES = MUL_STAGES_DEF
) (
   input logic                  ap_clk,
   input logic                  ap_rst,
   fpga_top_mul_share_if.slave  bus
);

   stage_t             st [MUL_STAGES];
   owner_t             ptr;
   owner_t             gnt_idx;
   logic [NUM_REQ-1:0] grant;
   logic [A_WIDTH-1:0] op_a;
   logic [B_WIDTH-1:0] op_b;
   logic [P_WIDTH-1:0] prod;
   logic [31:0]        op_count_q;
   logic               out_valid;
   owner_t             out_owner;
   logic               adv;
   logic               accept;
   logic               any_valid;

   assign out_valid = st[MUL_STAGES-1].valid;
   assign out_owner = st[MUL_STAGES-1].owner;
   assign adv       = !out_valid || bus.rsp_ready[out_owner];

   fpga_top_mul_share_rr #(.NUM_REQ(NUM_REQ)) u_rr (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .en    (adv && !ap_rst),
      .grant (grant),
      .idx   (gnt_idx)
   );

   assign accept = |(bus.req_valid & grant);

   always_comb begin
      op_a = bus.req_a[gnt_idx*A_WIDTH +: A_WIDTH];
      op_b = bus.req_b[gnt_idx*B_WIDTH +: B_WIDTH];
   end

   fpga_top_mul_mul_10s_10ns_16_1_1 u_mul (
      .din0 (op_a),
      .din1 (op_b),
      .dout (prod)
   );

   // Payload only moves with a valid entry, so rsp_p keeps its last result across bubbles.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         for (int k = 0; k < MUL_STAGES; k++) st[k] <= '0;
         ptr        <= '0;
         op_count_q <= '0;
      end else if (adv) begin
         st[0].valid <= accept;
         if (accept) begin
            st[0].owner <= gnt_idx;
            st[0].p     <= prod;
            ptr         <= (gnt_idx == owner_t'(NUM_REQ-1)) ? '0 : gnt_idx + owner_t'(1);
            op_count_q  <= op_count_q + 32'd1;
         end
         for (int k = 1; k < MUL_STAGES; k++) begin
            st[k].valid <= st[k-1].valid;
            if (st[k-1].valid) begin
               st[k].owner <= st[k-1].owner;
               st[k].p     <= st[k-1].p;
            end
         end
      end
   end

   always_comb begin
      any_valid = 1'b0;
      for (int k = 0; k < MUL_STAGES; k++) any_valid = any_valid | st[k].valid;
   end

   always_comb begin
      bus.rsp_valid = '0;
      if (out_valid) bus.rsp_valid[out_owner] = 1'b1;
   end

   assign bus.req_ready = grant;
   assign bus.rsp_p     = st[MUL_STAGES-1].p;
   assign bus.busy      = any_valid;
   assign bus.op_count  = op_count_q;

endmodule
